// File: rtl/std_fifo_mc_pkg.sv
// Shared helpers for the multi-channel FIFO: width derivation and count-vector slicing.
package std_fifo_mc_pkg;

    // Bits needed to represent v (minimum 1); log2(CHANNELS-1) sizes a channel select.
    function automatic int log2c(input int unsigned v);
        int r;
        r = 1;
        for (int i = 0; i < 32; i++) begin
            if ((v >> i) != 0) r = i + 1;
        end
        return r;
    endfunction

    // LSB of channel c inside the packed count vector, each field a+1 bits wide.
    function automatic int ch_lsb(input int c, input int a);
        return c * (a + 1);
    endfunction

endpackage

// File: rtl/std_fifo_mc_ptr.sv
// Per-channel read/write pointer pair with the status flags derived from it.
module std_fifo_mc_ptr
    import std_fifo_mc_pkg::*;
#(
    parameter int DEPTH              = 16,
    parameter int A                  = 4,
    parameter int ALMOST_EMPTY_COUNT = 1,
    parameter int ALMOST_FULL_COUNT  = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_inc,
    input  logic         rd_inc,
    output logic [A-1:0] wr_addr,
    output logic [A-1:0] rd_addr,
    output logic [A:0]   cnt,
    output logic         empty,
    output logic         full,
    output logic         almost_empty,
    output logic         almost_full
);
    localparam int AE_TH = 1 + ALMOST_EMPTY_COUNT;
    localparam int AF_TH = DEPTH - 1 - ALMOST_FULL_COUNT;

    // One extra MSB per pointer tells a full ring from an empty one.
    logic [A:0] wp, rp;

    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (wr_inc) wp <= wp + 1'b1;
            if (rd_inc) rp <= rp + 1'b1;
        end
    end

    assign wr_addr      = wp[A-1:0];
    assign rd_addr      = rp[A-1:0];
    assign cnt          = wp - rp;
    assign empty        = (wp == rp);
    assign full         = (wp[A-1:0] == rp[A-1:0]) && (wp[A] != rp[A]);
    assign almost_empty = int'(cnt) < AE_TH;
    assign almost_full  = int'(cnt) > AF_TH;

endmodule

// File: rtl/std_fifo_mc.sv
// Multi-channel FIFO: CHANNELS queues in one shared RAM, one push and one pop per cycle.
module std_fifo_mc
    import std_fifo_mc_pkg::*;
#(
    parameter int WIDTH              = 8,
    parameter int CHANNELS           = 4,
    parameter int DEPTH              = 16,
    parameter int CH_WIDTH           = log2c(CHANNELS - 1),
    parameter int DEPTH_ADDR_WIDTH   = log2c(DEPTH - 1),
    parameter int ALMOST_EMPTY_COUNT = 1,
    parameter int ALMOST_FULL_COUNT  = 1
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     push,
    input  logic [CH_WIDTH-1:0]                      push_ch,
    input  logic [WIDTH-1:0]                         d,
    input  logic                                     pop,
    input  logic [CH_WIDTH-1:0]                      pop_ch,
    output logic [WIDTH-1:0]                         q,
    output logic                                     q_valid,
    output logic [CH_WIDTH-1:0]                      q_ch,
    output logic [CHANNELS-1:0]                      empty,
    output logic [CHANNELS-1:0]                      full,
    output logic [CHANNELS-1:0]                      almost_empty,
    output logic [CHANNELS-1:0]                      almost_full,
    output logic [CHANNELS*(DEPTH_ADDR_WIDTH+1)-1:0] count,
    output logic                                     overflow,
    output logic                                     underflow
);
    localparam int A  = DEPTH_ADDR_WIDTH;
    localparam int CW = A + 1;

    logic [CHANNELS-1:0]        wr_inc, rd_inc;
    logic [CHANNELS-1:0][A-1:0] wr_addr, rd_addr;
    logic                       push_ok, pop_ok;
    logic [WIDTH-1:0]           mem [CHANNELS*DEPTH];

    // Accept decisions use start-of-cycle flags only, so same-channel push+pop never bypasses.
    assign push_ok = push && !full[push_ch];
    assign pop_ok  = pop && !empty[pop_ch];

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        assign wr_inc[c] = push_ok && (push_ch == CH_WIDTH'(c));
        assign rd_inc[c] = pop_ok && (pop_ch == CH_WIDTH'(c));

        std_fifo_mc_ptr #(
            .DEPTH             (DEPTH),
            .A                 (A),
            .ALMOST_EMPTY_COUNT(ALMOST_EMPTY_COUNT),
            .ALMOST_FULL_COUNT (ALMOST_FULL_COUNT)
        ) u_ptr (
            .clk         (clk),
            .rst         (rst),
            .wr_inc      (wr_inc[c]),
            .rd_inc      (rd_inc[c]),
            .wr_addr     (wr_addr[c]),
            .rd_addr     (rd_addr[c]),
            .cnt         (count[ch_lsb(c, A) +: CW]),
            .empty       (empty[c]),
            .full        (full[c]),
            .almost_empty(almost_empty[c]),
            .almost_full (almost_full[c])
        );
    end

    // RAM has no reset; contents left behind by a reset are unreachable behind zeroed pointers.
    always_ff @(posedge clk) begin
        if (push_ok && !rst) mem[{push_ch, wr_addr[push_ch]}] <= d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q         <= '0;
            q_ch      <= '0;
            q_valid   <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            q_valid <= pop_ok;
            if (pop_ok) begin
                q    <= mem[{pop_ch, rd_addr[pop_ch]}];
                q_ch <= pop_ch;
            end
            if (push && full[push_ch])  overflow  <= 1'b1;
            if (pop && empty[pop_ch])   underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_std_fifo_mc.sv
// Randomised + directed bench for std_fifo_mc: queue-per-channel model, scoreboard on q/q_ch.
module tb_std_fifo_mc;
    localparam int WIDTH = 8;
    localparam int CHANNELS = 4;
    localparam int DEPTH = 16;
    localparam int CHW = 2;
    localparam int A = 4;

    logic                        clk = 1'b0;
    logic                        rst = 1'b0;
    logic                        push = 1'b0;
    logic [CHW-1:0]              push_ch = '0;
    logic [WIDTH-1:0]            d = '0;
    logic                        pop = 1'b0;
    logic [CHW-1:0]              pop_ch = '0;
    logic [WIDTH-1:0]            q;
    logic                        q_valid;
    logic [CHW-1:0]              q_ch;
    logic [CHANNELS-1:0]         empty, full, almost_empty, almost_full;
    logic [CHANNELS*(A+1)-1:0]   count;
    logic                        overflow, underflow;

    std_fifo_mc #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .push(push), .push_ch(push_ch), .d(d),
        .pop(pop), .pop_ch(pop_ch), .q(q), .q_valid(q_valid), .q_ch(q_ch),
        .empty(empty), .full(full), .almost_empty(almost_empty), .almost_full(almost_full),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [WIDTH-1:0] mq [CHANNELS][$];
    logic [WIDTH-1:0] exp_d [$];
    int               exp_c [$];
    bit               m_ovf, m_unf;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every presented output must match the oldest expected pop.
    always @(negedge clk) begin
        if (q_valid === 1'b1) begin
            if (exp_d.size() == 0) begin
                chk("q_valid_spurious", 32'(q_valid), 32'd0);
            end else begin
                chk("q_data", 32'(q), 32'(exp_d.pop_front()));
                chk("q_ch", 32'(q_ch), 32'(exp_c.pop_front()));
            end
        end
    end

    task automatic check_status(input string tag);
        logic [CHANNELS*(A+1)-1:0] ec;
        logic [CHANNELS-1:0] ee, ef, eae, eaf;
        for (int c = 0; c < CHANNELS; c++) begin
            int n;
            n = mq[c].size();
            ec[c*(A+1) +: A+1] = (A+1)'(n);
            ee[c]  = (n == 0);
            ef[c]  = (n == DEPTH);
            eae[c] = (n < 2);
            eaf[c] = (n > DEPTH - 2);
        end
        chk({tag, ":count"}, 32'(count), 32'(ec));
        chk({tag, ":empty"}, 32'(empty), 32'(ee));
        chk({tag, ":full"}, 32'(full), 32'(ef));
        chk({tag, ":almost_empty"}, 32'(almost_empty), 32'(eae));
        chk({tag, ":almost_full"}, 32'(almost_full), 32'(eaf));
        chk({tag, ":overflow"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ":underflow"}, 32'(underflow), 32'(m_unf));
    endtask

    task automatic step(input bit ps, input int pc, input logic [WIDTH-1:0] dd,
                        input bit pp, input int qc, input string tag);
        bit pacc, qacc;
        push = ps; push_ch = CHW'(pc); d = dd; pop = pp; pop_ch = CHW'(qc);
        pacc = ps && (mq[pc].size() < DEPTH);
        qacc = pp && (mq[qc].size() > 0);
        if (ps && !pacc) m_ovf = 1'b1;
        if (pp && !qacc) m_unf = 1'b1;
        if (qacc) begin
            exp_d.push_back(mq[qc].pop_front());
            exp_c.push_back(qc);
        end
        if (pacc) mq[pc].push_back(dd);
        @(posedge clk); #1;
        push = 1'b0; pop = 1'b0;
        check_status(tag);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1; push = 1'b0; pop = 1'b0;
        for (int c = 0; c < CHANNELS; c++) mq[c].delete();
        m_ovf = 1'b0; m_unf = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check_status(tag);
        chk({tag, ":q_valid"}, 32'(q_valid), 32'd0);
        chk({tag, ":q"}, 32'(q), 32'd0);
        chk({tag, ":q_ch"}, 32'(q_ch), 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 8'h00, 0, 0, "idle");
    endtask

    initial begin
        do_reset("reset");

        // 1: basic push/pop on ch2
        step(1, 2, 8'hA1, 0, 0, "t1_push");
        step(1, 2, 8'hA2, 0, 0, "t1_push");
        step(0, 0, 8'h00, 1, 2, "t1_pop");
        step(0, 0, 8'h00, 1, 2, "t1_pop");
        idle(1);

        // 2: fill ch1, overflow, drain in order
        for (int i = 0; i < DEPTH; i++) step(1, 1, 8'(i), 0, 0, "t2_fill");
        step(1, 1, 8'hEE, 0, 0, "t2_ovf");
        for (int i = 0; i < DEPTH; i++) step(0, 0, 8'h00, 1, 1, "t2_drain");
        idle(1);

        // 3: pop empty ch3 with simultaneous push
        step(1, 3, 8'h55, 1, 3, "t3_both");
        chk("t3_q_valid", 32'(q_valid), 32'd0);
        step(0, 0, 8'h00, 1, 3, "t3_pop");
        idle(1);

        // 4: push+pop on full ch0, then at count 8
        for (int i = 0; i < DEPTH; i++) step(1, 0, 8'(8'h30 + i), 0, 0, "t4_fill");
        step(1, 0, 8'hBB, 1, 0, "t4_full_both");
        for (int i = 0; i < 7; i++) step(0, 0, 8'h00, 1, 0, "t4_down");
        step(1, 0, 8'hCC, 1, 0, "t4_mid_both");
        for (int i = 0; i < 8; i++) step(0, 0, 8'h00, 1, 0, "t4_drain");
        idle(1);

        // 5: interleaved channels
        step(1, 0, 8'h10, 0, 0, "t5");
        step(1, 1, 8'h20, 0, 0, "t5");
        step(1, 0, 8'h11, 0, 0, "t5");
        step(0, 0, 8'h00, 1, 1, "t5");
        step(0, 0, 8'h00, 1, 0, "t5");
        step(0, 0, 8'h00, 1, 0, "t5");
        idle(1);

        // 6: stream through ch2 past pointer wrap, reset mid-stream
        for (int i = 0; i < 40; i++) step(1, 2, 8'(i + 8'h40), i >= 3, 2, "t6_stream");
        for (int i = 0; i < 3; i++) step(1, 2, 8'(i + 8'h90), 0, 0, "t6_pre_rst");
        idle(1);
        do_reset("t6_rst");
        step(1, 2, 8'h7E, 0, 0, "t6_post");
        step(0, 0, 8'h00, 1, 2, "t6_post");
        idle(1);

        // Random traffic with per-phase bias to hit both full and empty
        for (int ph = 0; ph < 8; ph++) begin
            int pw;
            pw = (ph % 2 == 0) ? 80 : 25;
            for (int i = 0; i < 250; i++) begin
                if ($urandom_range(0, 299) == 0) begin
                    idle(1);
                    do_reset("rand_rst");
                end else begin
                    step($urandom_range(0, 99) < pw, $urandom_range(0, CHANNELS-1), 8'($urandom),
                         $urandom_range(0, 99) < (100 - pw), $urandom_range(0, CHANNELS-1), "rand");
                end
            end
        end
        idle(2);
        chk("pending_outputs", 32'(exp_d.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
